// File: rtl/ped_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ped_pkg : shared states and constants for the pedestrian phase logic. |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package ped_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PENDING = 3'd1,
    WALK    = 3'd2,
    CLEAR   = 3'd3,
    GAP     = 3'd4
  } ped_state_t;

  localparam logic [7:0] WALK_ON  = 8'hFF;
  localparam logic [7:0] WALK_OFF = 8'h00;

  localparam int DEF_WALK_TIME  = 12;
  localparam int DEF_CLEAR_TIME = 4;
  localparam int DEF_MIN_GAP    = 8;
  localparam int DEF_CNT_W      = 7;

endpackage
`default_nettype wire

// File: rtl/tick_down_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tick_down_counter : loadable down-counter stepped by a tick strobe.   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tick_down_counter #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  // Load wins over a coincident tick; the count saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = tick && (count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/ped_phase_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ped_phase_scheduler : pedestrian request / walk / clear / gap FSM.    |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module ped_phase_scheduler
  import ped_pkg::*;
#(
  parameter int WALK_TIME  = DEF_WALK_TIME,
  parameter int CLEAR_TIME = DEF_CLEAR_TIME,
  parameter int MIN_GAP    = DEF_MIN_GAP,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             ped_btn,
  input  logic             veh_idle,
  output logic             ped_req,
  output logic             lane_hold,
  output logic [7:0]       walk_light,
  output logic [CNT_W-1:0] remaining,
  output logic             ped_done
);

  ped_state_t       r_state;
  logic             r_btn_q;
  logic             r_pend;
  logic             r_flash;
  logic             w_press;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_last;

  assign w_press = ped_btn & ~r_btn_q;

  // Every state exit reloads the counter, zero when heading back to idle.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      PENDING: if (veh_idle) begin
        w_load     = 1'b1;
        w_load_val = CNT_W'(WALK_TIME);
      end
      WALK: if (w_last) begin
        w_load     = 1'b1;
        w_load_val = CNT_W'(CLEAR_TIME);
      end
      CLEAR: if (w_last) begin
        w_load     = 1'b1;
        w_load_val = CNT_W'(MIN_GAP);
      end
      GAP: if (w_last) begin
        w_load     = 1'b1;
        w_load_val = '0;
      end
      default: ;
    endcase
  end

  tick_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .load     (w_load),
    .load_val (w_load_val),
    .count    (remaining),
    .last     (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_btn_q    <= 1'b0;
      r_pend     <= 1'b0;
      r_flash    <= 1'b0;
      ped_req    <= 1'b0;
      lane_hold  <= 1'b0;
      walk_light <= WALK_OFF;
      ped_done   <= 1'b0;
    end else begin
      r_btn_q  <= ped_btn;
      ped_done <= 1'b0;
      case (r_state)
        IDLE: if (w_press) begin
          r_state <= PENDING;
          ped_req <= 1'b1;
        end
        PENDING: if (veh_idle) begin
          // A press on this edge is absorbed by the service now starting.
          r_state    <= WALK;
          r_pend     <= 1'b0;
          ped_req    <= 1'b0;
          lane_hold  <= 1'b1;
          walk_light <= WALK_ON;
        end
        WALK: begin
          if (w_press) r_pend <= 1'b1;
          if (w_last) begin
            r_state    <= CLEAR;
            r_flash    <= 1'b0;
            walk_light <= WALK_OFF;
          end
        end
        CLEAR: begin
          if (w_press) r_pend <= 1'b1;
          if (w_last) begin
            r_state    <= GAP;
            r_flash    <= 1'b0;
            lane_hold  <= 1'b0;
            walk_light <= WALK_OFF;
            ped_done   <= 1'b1;
          end else if (tick) begin
            r_flash    <= ~r_flash;
            walk_light <= r_flash ? WALK_OFF : WALK_ON;
          end
        end
        GAP: begin
          if (w_press) r_pend <= 1'b1;
          if (w_last) begin
            if (r_pend || w_press) begin
              r_state <= PENDING;
              ped_req <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ped_phase_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_ped_phase_scheduler : directed self-checking bench for the FSM.    |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_ped_phase_scheduler;

  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick;
  logic          ped_btn;
  logic          veh_idle;
  logic          ped_req;
  logic          lane_hold;
  logic [7:0]    walk_light;
  logic [CW-1:0] remaining;
  logic          ped_done;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  ped_phase_scheduler #(
    .WALK_TIME  (12),
    .CLEAR_TIME (4),
    .MIN_GAP    (8),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .ped_btn    (ped_btn),
    .veh_idle   (veh_idle),
    .ped_req    (ped_req),
    .lane_hold  (lane_hold),
    .walk_light (walk_light),
    .remaining  (remaining),
    .ped_done   (ped_done)
  );

  always @(negedge clk) if (ped_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; ped_btn = 1'b0; veh_idle = 1'b0;
    #12;
    chk("rst_req", ped_req, 0);
    chk("rst_hold", lane_hold, 0);
    chk("rst_walk", walk_light, 8'h00);
    chk("rst_rem", remaining, 0);
    chk("rst_done", ped_done, 0);
    @(negedge clk); rst_n = 1'b1;
    step(0);

    // Basic cycle with vehicles already idle, ticks every other clock.
    veh_idle = 1'b1; ped_btn = 1'b1;
    step(0);
    chk("basic_req", ped_req, 1);
    chk("basic_hold_pend", lane_hold, 0);
    ped_btn = 1'b0;
    step(0);
    chk("basic_hold", lane_hold, 1);
    chk("basic_walk_on", walk_light, 8'hFF);
    chk("basic_rem12", remaining, 12);
    for (int k = 1; k <= 12; k++) begin
      step(0);
      step(1);
      if (k < 12) begin
        chk("walk_rem", remaining, 12 - k);
        chk("walk_lit", walk_light, 8'hFF);
      end
    end
    chk("clear_rem4", remaining, 4);
    chk("clear_dark0", walk_light, 8'h00);
    chk("clear_hold", lane_hold, 1);
    for (int k = 1; k <= 3; k++) begin
      step(1);
      chk("clear_flash", walk_light, (k % 2 == 1) ? 8'hFF : 8'h00);
      chk("clear_rem", remaining, 4 - k);
    end
    step(1);
    chk("done_pulse", ped_done, 1);
    chk("gap_hold", lane_hold, 0);
    chk("gap_walk", walk_light, 8'h00);
    chk("gap_rem8", remaining, 8);
    step(0);
    chk("done_once", ped_done, 0);
    for (int k = 1; k <= 7; k++) begin
      step(1);
      chk("gap_hold_low", lane_hold, 0);
    end
    chk("gap_rem1", remaining, 1);
    step(1);
    chk("idle_rem", remaining, 0);
    chk("idle_req", ped_req, 0);
    step(0);
    chk("idle_stay", ped_req, 0);

    // Asynchronous reset in the middle of WALK.
    ped_btn = 1'b1; step(0); ped_btn = 1'b0; step(0);
    step(1); step(1);
    chk("mid_rem10", remaining, 10);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("async_hold", lane_hold, 0);
    chk("async_walk", walk_light, 8'h00);
    chk("async_rem", remaining, 0);
    @(negedge clk); rst_n = 1'b1;
    step(0);
    chk("post_rst_rem", remaining, 0);
    chk("post_rst_req", ped_req, 0);

    // Yield wait: request held while vehicles are still moving.
    veh_idle = 1'b0; ped_btn = 1'b1;
    step(0);
    chk("yield_req", ped_req, 1);
    ped_btn = 1'b0;
    repeat (50) step(1);
    chk("yield_req_hold", ped_req, 1);
    chk("yield_no_hold", lane_hold, 0);
    chk("yield_rem", remaining, 0);
    veh_idle = 1'b1;
    step(0);
    chk("yield_grant", lane_hold, 1);
    chk("yield_rem12", remaining, 12);

    // Press during WALK (with veh_idle dropped) and during GAP: one extra service.
    veh_idle = 1'b0;
    ped_btn = 1'b1; step(1); ped_btn = 1'b0;
    chk("walk_noabort", lane_hold, 1);
    chk("walk_rem11", remaining, 11);
    repeat (15) step(1);
    chk("pend_done", ped_done, 1);
    step(1);
    ped_btn = 1'b1; step(1); ped_btn = 1'b0;
    chk("gap_rem6", remaining, 6);
    repeat (6) step(1);
    chk("repend_req", ped_req, 1);
    chk("repend_rem", remaining, 0);
    step(0);
    chk("repend_wait", ped_req, 1);
    veh_idle = 1'b1;
    step(1);
    chk("coinc_tick_rem", remaining, 12);
    chk("coinc_hold", lane_hold, 1);
    repeat (16) step(1);
    chk("second_done", ped_done, 1);
    repeat (8) step(1);
    chk("single_extra", ped_req, 0);
    step(0);
    chk("single_extra_idle", ped_req, 0);

    // Press on the final GAP tick, then a press on the PENDING->WALK edge.
    ped_btn = 1'b1; step(0); ped_btn = 1'b0; step(0);
    repeat (16) step(1);
    repeat (7) step(1);
    chk("bnd_gap_rem1", remaining, 1);
    veh_idle = 1'b0;
    ped_btn = 1'b1; step(1); ped_btn = 1'b0;
    chk("bnd_pend", ped_req, 1);
    step(0);
    veh_idle = 1'b1; ped_btn = 1'b1;
    step(1);
    ped_btn = 1'b0;
    chk("bnd_walk_rem", remaining, 12);
    repeat (24) step(1);
    chk("bnd_drop_idle", ped_req, 0);
    chk("bnd_drop_rem", remaining, 0);

    // Held button produces a single service only.
    done_cnt = 0;
    ped_btn = 1'b1;
    step(0);
    chk("held_req", ped_req, 1);
    repeat (99) step(1);
    chk("held_idle", ped_req, 0);
    chk("held_once", done_cnt, 1);
    ped_btn = 1'b0;
    step(0);
    chk("held_release", ped_req, 0);
    ped_btn = 1'b1;
    step(0);
    chk("held_repress", ped_req, 1);
    ped_btn = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ped_phase_scheduler.md
# ped_phase_scheduler

Sequences the pedestrian crossing phase at an intersection. Latches pedestrian button presses and requests a pedestrian slot from the vehicle-phase controller. Once the vehicles yield, holds all lanes red and drives the walk light for a timed WALK interval and a flashing CLEAR interval. It then enforces a minimum vehicle gap before serving another request. All interval timing counts a one-cycle `tick` strobe, not raw clocks.

## Interface
Parameters:
- `WALK_TIME`, 12, ticks of steady walk; must be ≥1.
- `CLEAR_TIME`, 4, ticks of flashing walk; must be ≥1.
- `MIN_GAP`, 8, ticks of vehicle service guaranteed after a pedestrian phase; must be ≥1.
- `CNT_W`, 7, counter width; every time parameter must be < 2^CNT_W.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tick` in 1: one-cycle timebase strobe.
- `ped_btn` in 1: button level, already synchronous to `clk`.
- `veh_idle` in 1: vehicle controller reports all lanes safely red.
- `ped_req` out 1: pedestrian slot requested.
- `lane_hold` out 1: vehicle lanes forced red.
- `walk_light` out 8: 8'hFF when lit, 8'h00 when dark.
- `remaining` out CNT_W: ticks left in the current timed state; 0 otherwise.
- `ped_done` out 1: one-cycle pulse at the end of CLEAR.

## Operation
Rising-edge detect on `ped_btn`:
- `btn_q` register; `press = ped_btn & ~btn_q`.
- A press in WALK, CLEAR or GAP sets `pend`. A press in IDLE moves the FSM to PENDING.
- A press in PENDING has no effect.

FSM states:
- IDLE: all outputs inactive. `press` → PENDING.
- PENDING: `ped_req=1`. `veh_idle=1` (sampled every clock, not only on tick) → WALK; counter loaded with WALK_TIME; `pend` cleared.
- WALK: `lane_hold=1`, `walk_light=8'hFF`. Counter decrements on each `tick`. A `tick` with counter==1 → CLEAR; counter loaded with CLEAR_TIME; flash phase set to 0 (dark).
- CLEAR: `lane_hold=1`. Flash phase toggles on each `tick`; `walk_light` = FF when phase=1, else 00. A `tick` with counter==1 → GAP; counter loaded with MIN_GAP; `ped_done` pulses.
- GAP: `lane_hold=0`, `ped_req=0`, `walk_light=00`. A `tick` with counter==1 → PENDING if `pend` (or a `press` in the same cycle), else IDLE.

Counter and output rules:
- Counter is zeroed when leaving GAP and is held at 0 in IDLE and PENDING.
- `remaining` = counter value.
- `veh_idle` is ignored outside PENDING.
- `veh_idle` dropping during WALK/CLEAR does not abort the phase; safety is owned by `lane_hold`.

## Timing
- Reset (asynchronous assert) values:
  - state IDLE; counter 0; `btn_q` 0; `pend` 0; flash phase 0.
  - `ped_req` 0, `lane_hold` 0, `walk_light` 8'h00, `remaining` 0, `ped_done` 0.
- Reset mid-phase drops `lane_hold` and `walk_light` immediately.
- Deassertion is released synchronously to `clk`.
- All outputs are registered: they reflect the new state in the cycle after the transition edge. `ped_done` is high for exactly that one cycle.
- Press → `ped_req` high: 1 clock.
- `veh_idle` seen in PENDING → `lane_hold` and `walk_light` high: 1 clock.
- The tick arriving in the same cycle as entry to WALK is not counted. WALK spans exactly WALK_TIME subsequent ticks; CLEAR and GAP follow the same rule.
- A press coinciding with the GAP→exit tick counts as pending.
- A press coinciding with the PENDING→WALK edge is dropped; the pedestrian is already being served.

## Structure
- Package `ped_pkg`:
  - state enum `ped_state_t` {IDLE, PENDING, WALK, CLEAR, GAP};
  - constants `WALK_ON=8'hFF`, `WALK_OFF=8'h00`;
  - default time constants.
- Sub-module `tick_down_counter`: loadable CNT_W down-counter with `load`, `load_val` and `tick` enable. It outputs `count` and `last` (tick & count==1).
- The FSM and edge detect stay in the top level.

## Test plan
- Reset mid-WALK: assert `rst_n=0` → all outputs 0 in the same cycle; after release, state is IDLE and `remaining=0`.
- Basic cycle, defaults, `veh_idle=1`: one press → `ped_req` next clock → WALK with `remaining=12`. Walk lit for 12 ticks, then CLEAR flashes 00/FF/00/FF over 4 ticks. `ped_done` pulses once, then `lane_hold` stays 0 for 8 ticks → IDLE.
- Yield wait: `veh_idle=0` for 50 clocks after a press → `ped_req` stays 1 and `lane_hold` stays 0. Raising `veh_idle` → `lane_hold=1` one clock later.
- Presses during WALK and during GAP: a single pending service occurs → after 8 GAP ticks, PENDING is re-entered (not IDLE) and exactly one more WALK follows.
- Boundary: a press in the same cycle as the final GAP tick → PENDING. `tick` coincident with the PENDING→WALK edge → WALK still lasts 12 further ticks.
- Held button (level high 100 clocks) → exactly one request; no re-trigger until it is released and pressed again.
